// File: rtl/csr_bank.sv
// Eight-location control/status register window: ID, scratch, control, sticky
// W1C status, interrupt mask and a free-running counter, with registered read data and irq.
module csr_bank #(
    parameter logic [13:0] BASE     = 14'h0000,
    parameter logic [7:0]  ID_VALUE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] adr,
    input  logic        we,
    input  logic [7:0]  dat_w,
    output logic [7:0]  dat_r,
    input  logic [7:0]  evt_in,
    output logic [7:0]  ctrl_out,
    output logic        irq
);

    localparam logic [2:0] OFF_ID      = 3'd0;
    localparam logic [2:0] OFF_SCRATCH = 3'd1;
    localparam logic [2:0] OFF_CTRL    = 3'd2;
    localparam logic [2:0] OFF_STATUS  = 3'd3;
    localparam logic [2:0] OFF_MASK    = 3'd4;
    localparam logic [2:0] OFF_CNT     = 3'd5;

    logic [7:0]  r_scratch;
    logic [7:0]  r_ctrl;
    logic [7:0]  r_status;
    logic [7:0]  r_mask;
    logic [7:0]  r_cnt;
    logic [7:0]  r_dat_r;
    logic        r_irq;

    logic [13:0] w_diff;
    logic        w_hit;
    logic [2:0]  w_off;
    logic        w_wr;
    logic [7:0]  w_clr;
    logic [7:0]  w_rd;

    // Modular subtraction: addresses below BASE wrap to large values and miss.
    assign w_diff = adr - BASE;
    assign w_hit  = (w_diff[13:3] == 11'd0);
    assign w_off  = w_diff[2:0];
    assign w_wr   = we & w_hit;
    assign w_clr  = (w_wr && (w_off == OFF_STATUS)) ? dat_w : 8'h00;

    always_comb begin
        w_rd = 8'h00;
        if (w_hit) begin
            case (w_off)
                OFF_ID:      w_rd = ID_VALUE;
                OFF_SCRATCH: w_rd = r_scratch;
                OFF_CTRL:    w_rd = r_ctrl;
                OFF_STATUS:  w_rd = r_status;
                OFF_MASK:    w_rd = r_mask;
                OFF_CNT:     w_rd = r_cnt;
                default:     w_rd = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scratch <= 8'h00;
            r_ctrl    <= 8'h00;
            r_status  <= 8'h00;
            r_mask    <= 8'h00;
            r_cnt     <= 8'h00;
            r_dat_r   <= 8'h00;
            r_irq     <= 1'b0;
        end else begin
            r_dat_r  <= w_rd;
            r_irq    <= |(r_status & r_mask);
            // New events win over a same-cycle clear of the same bit.
            r_status <= (r_status & ~w_clr) | evt_in;
            if (w_wr && (w_off == OFF_SCRATCH)) r_scratch <= dat_w;
            if (w_wr && (w_off == OFF_CTRL))    r_ctrl    <= dat_w;
            if (w_wr && (w_off == OFF_MASK))    r_mask    <= dat_w;
            if (w_wr && (w_off == OFF_CNT))     r_cnt     <= dat_w;
            else if (r_ctrl[0])                 r_cnt     <= r_cnt + 8'd1;
        end
    end

    assign dat_r    = r_dat_r;
    assign ctrl_out = r_ctrl;
    assign irq      = r_irq;

endmodule
